// File: rtl/disp_pkg.sv
// Shared types and helpers for the 7-segment display scanning blocks.
package disp_pkg;

   typedef logic [3:0] bcd_t;
   typedef bcd_t [3:0] bcd4_t;

   localparam int         BCD_MAX = 9;
   localparam logic [3:0] AN_OFF  = 4'b1111;

   function automatic logic is_valid_bcd(input bcd_t d);
      return (d <= bcd_t'(BCD_MAX));
   endfunction

endpackage

// File: rtl/disp_prescaler.sv
// Free-running slot tick generator: tick is high for one clk every PRESCALE cycles.
module disp_prescaler #(
   parameter int PRESCALE = 100000,
   parameter int CNT_W    = 20
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

   logic [CNT_W-1:0] cnt_reg;

   assign tick = (cnt_reg == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= '0;
      end else if (tick) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_reg + CNT_W'(1);
      end
   end

endmodule

// File: rtl/disp_scan4.sv
// Four-digit multiplexed scanner for a common-anode display; new values land only at frame boundaries.
// Build option: define DISP_SCAN4_LZ_BLANK_EN to blank leading zeros on digits 3..1.
module disp_scan4
   import disp_pkg::*;
#(
   parameter int PRESCALE = 100000,
   parameter int CNT_W    = 20
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   output logic [3:0]  digit_n,
   output logic [3:0]  an_n,
   output logic        frame_done
);

   logic       tick;
   logic       boundary;
   logic [1:0] idx_reg;
   bcd4_t      pending_reg;
   logic       pend_valid_reg;
   bcd4_t      shadow_reg;
   logic       boundary_d_reg;
   logic [3:0] digit_n_reg;
   logic [3:0] an_n_reg;
   logic       frame_done_reg;

   logic [3:0] digit_n_next;
   logic [3:0] an_n_next;
   logic [3:0] digit_valid;
   logic [3:0] show;

   disp_prescaler #(
      .PRESCALE (PRESCALE),
      .CNT_W    (CNT_W)
   ) u_prescaler (
      .clk   (clk),
      .rst_n (rst_n),
      .tick  (tick)
   );

   assign boundary = tick && (idx_reg == 2'd3);

`ifdef DISP_SCAN4_LZ_BLANK_EN
   logic [3:0] digit_zero;
   logic [3:0] lead_zero;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         assign digit_valid[gi] = is_valid_bcd(shadow_reg[gi]);
`ifdef DISP_SCAN4_LZ_BLANK_EN
         assign digit_zero[gi] = (shadow_reg[gi] == 4'd0);
         // A digit is a leading zero when it and every digit above it are zero.
         assign lead_zero[gi]  = &digit_zero[3:gi];
         if (gi == 0) begin : g_units
            assign show[gi] = digit_valid[gi];
         end else begin : g_upper
            assign show[gi] = digit_valid[gi] && !lead_zero[gi];
         end
`else
         assign show[gi] = digit_valid[gi];
`endif
      end
   endgenerate

   always_comb begin
      digit_n_next = AN_OFF;
      an_n_next    = AN_OFF;
      if (show[idx_reg]) begin
         digit_n_next = ~shadow_reg[idx_reg];
         an_n_next    = ~(4'b0001 << idx_reg);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_reg        <= 2'd0;
         pending_reg    <= '0;
         pend_valid_reg <= 1'b0;
         shadow_reg     <= '0;
         boundary_d_reg <= 1'b0;
      end else begin
         if (tick) begin
            idx_reg <= idx_reg + 2'd1;
         end
         boundary_d_reg <= boundary;
         if (boundary && pend_valid_reg) begin
            shadow_reg     <= pending_reg;
            pend_valid_reg <= 1'b0;
         end
         // A load coinciding with the boundary is held for the following frame.
         if (load) begin
            pending_reg    <= value;
            pend_valid_reg <= 1'b1;
         end
      end
   end

   // frame_done is delayed one extra stage so it coincides with slot 0 reaching the outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         digit_n_reg    <= AN_OFF;
         an_n_reg       <= AN_OFF;
         frame_done_reg <= 1'b0;
      end else begin
         digit_n_reg    <= digit_n_next;
         an_n_reg       <= an_n_next;
         frame_done_reg <= boundary_d_reg;
      end
   end

   assign digit_n    = digit_n_reg;
   assign an_n       = an_n_reg;
   assign frame_done = frame_done_reg;

endmodule
